fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BOOT_ADDR, 32'h0000_0000, first fetch address after reset, SHALL be provided.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries (power of two, >=2), SHALL be provided.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_req_o  output  1  instruction memory request valid.
REQ-006 imem_addr_o  output  32  request word address.
REQ-007 imem_gnt_i  input  1  request accepted this cycle.
REQ-008 imem_rvalid_i  input  1  response data valid.
REQ-009 imem_rdata_i  input  32  response instruction word.
REQ-010 redirect_i  input  1  taken jump/branch; overrides sequential fetch.
REQ-011 redirect_addr_i  input  32  redirect target from ALU/branch adder.
REQ-012 instr_valid_o  output  1  buffer head valid toward decoder.
REQ-013 instr_ready_i  input  1  decoder accepts head.
REQ-014 instr_o  output  32  head instruction word.
REQ-015 instr_pc_o  output  32  address of head instruction.
REQ-016 misaligned_o  output  1  redirect target misaligned (macro-dependent).

Function
REQ-017 States IDLE, REQ, WAIT, FLUSH; at most one memory request outstanding.
REQ-018 IDLE: next cycle -> REQ when occupancy + outstanding < BUF_DEPTH, else remain.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch_pc; on gnt -> WAIT, fetch_pc += 4 (mod 2^32, wrap to 0 silently).
REQ-020 REQ without gnt: req and addr held stable.
REQ-021 WAIT: on rvalid push {req_pc, rdata}; -> REQ if space remains after push, else IDLE.
REQ-022 Head pops on instr_valid_o && instr_ready_i; push and pop in same cycle SHALL both occur, occupancy unchanged.
REQ-023 instr_valid_o earliest 1 cycle after rvalid; instr_o/instr_pc_o stable while valid && !ready.
REQ-024 Redirect SHALL take priority over all other events: buffer flushed same cycle, fetch_pc <= redirect_addr_i, no pop counted.
REQ-025 Redirect in WAIT without rvalid, or in REQ with gnt: -> FLUSH; next rvalid discarded, then -> REQ.
REQ-026 Redirect in WAIT coinciding with rvalid: response discarded, -> REQ.
REQ-027 Redirect in IDLE, FLUSH, or REQ without gnt: -> REQ (FLUSH keeps discarding its pending response first).
REQ-028 imem_addr_o SHALL show redirect target the cycle after redirect_i.

Reset
REQ-029 While rst high: state IDLE, fetch_pc=BOOT_ADDR, buffer empty, imem_req_o=0, instr_valid_o=0, misaligned_o=0, instr_o=0, instr_pc_o=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; any rvalid in the first cycle after reset release SHALL be ignored.
REQ-031 First imem_req_o with addr BOOT_ADDR SHALL assert 2 cycles after rst release.

Configuration
REQ-032 With FETCH_MISALIGN_CHECK_EN defined: redirect with addr[1:0]!=0 pulses misaligned_o 1 cycle, flushes buffer, enters IDLE and issues no request until next aligned redirect.
REQ-033 Without FETCH_MISALIGN_CHECK_EN: redirect_addr_i[1:0] forced to 0, misaligned_o tied 0.

Structure
REQ-034 Package holds fetch state enum, BOOT_ADDR default, ctrl-transfer encodings shared with program counter/decoder.
REQ-035 Buffer SHALL be sub-module fetch_fifo (push, pop, flush, full, empty, count).

Verification
REQ-036 Reset release, gnt and rvalid always 1 -> addrs 0,4,8,...; first instr_valid_o with instr_pc_o=0.
REQ-037 instr_ready_i=0, BUF_DEPTH=2 -> exactly 2 words buffered, imem_req_o drops, resumes after one pop.
REQ-038 redirect to 0x100 while WAIT, rvalid 2 cycles later -> that word dropped, next req addr 0x100, buffer empty.
REQ-039 redirect coincident with rvalid -> response dropped, req addr = target next cycle, no FLUSH.
REQ-040 Macro on, redirect to 0x102 -> misaligned_o 1-cycle pulse, no req until redirect to 0x200; macro off -> req addr 0x100.
REQ-041 rst asserted during WAIT -> all outputs reset values immediately; stray rvalid after release not buffered.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: fetch FSM states, boot address default, control-transfer
// encodings used by the program counter and decoder, and the buffered entry format.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      CT_NONE   = 2'd0,
      CT_BRANCH = 2'd1,
      CT_JAL    = 2'd2,
      CT_JALR   = 2'd3
   } ctrl_xfer_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Instruction buffer between fetch and decode: power-of-two circular FIFO with
// single-cycle flush that overrides push and pop.
module fetch_fifo
   import fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  fetch_entry_t     wdata_i,
   output fetch_entry_t     rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o && !flush_i;
      do_pop   = pop_i && !empty_o && !flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the top masks the head while the buffer is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding memory requests into a small buffer.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        misaligned_o
);

   localparam int              CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             boot_q, boot_d, halt_q, halt_d, mis_q, mis_d;
   logic             push, pop, flush, resp_pending, redir_bad;
   logic [31:0]      redir_tgt;
   logic [CNT_W-1:0] fifo_count, count_after;
   logic             fifo_empty, unused_fifo_full;
   fetch_entry_t     push_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_bad = redirect_i && (redirect_addr_i[1:0] != 2'b00);
   assign redir_tgt = redirect_addr_i;
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^redirect_addr_i[1:0];
   assign redir_bad       = 1'b0;
   assign redir_tgt       = word_align(redirect_addr_i);
`endif

   // Any response still owed by memory at a redirect must be swallowed in FLUSH.
   assign resp_pending = ((state_q == ST_REQ)   &&  imem_gnt_i)    ||
                         ((state_q == ST_WAIT)  && !imem_rvalid_i) ||
                         ((state_q == ST_FLUSH) && !imem_rvalid_i);
   assign count_after  = fifo_count + CNT_W'(1) - CNT_W'(pop);
   assign boot_d       = 1'b0;
   assign mis_d        = redir_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= BOOT_ADDR;
         boot_q     <= 1'b1;
         halt_q     <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         boot_q     <= boot_d;
         halt_q     <= halt_d;
         mis_q      <= mis_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      halt_d     = halt_q;
      case (state_q)
         ST_IDLE:  if (!boot_q && !halt_q && (fifo_count < DEPTH_C)) state_d = ST_REQ;
         ST_REQ:   if (imem_gnt_i) begin
                      state_d    = ST_WAIT;
                      fetch_pc_d = fetch_pc_q + 32'd4;
                   end
         ST_WAIT:  if (imem_rvalid_i) state_d = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
         ST_FLUSH: if (imem_rvalid_i) state_d = halt_q ? ST_IDLE : ST_REQ;
         default:  state_d = ST_IDLE;
      endcase
      if (redirect_i) begin
         halt_d = redir_bad;
         if (!redir_bad) fetch_pc_d = redir_tgt;
         if (resp_pending)   state_d = ST_FLUSH;
         else if (redir_bad) state_d = ST_IDLE;
         else                state_d = ST_REQ;
      end
   end

   always_comb begin
      imem_req_o = (state_q == ST_REQ);
      push       = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
      pop        = instr_valid_o && instr_ready_i && !redirect_i;
      flush      = redirect_i;
      push_entry = '{pc: fetch_pc_q - 32'd4, instr: imem_rdata_i};
   end

   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = !fifo_empty;
   assign instr_o       = instr_valid_o ? head.instr : 32'd0;
   assign instr_pc_o    = instr_valid_o ? head.pc    : 32'd0;
   assign misaligned_o  = mis_q;

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (push_entry),
      .rdata_o (head),
      .full_o  (unused_fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule
